// File: rtl/frame_id_guard.sv
// frame_id_guard
// Store-and-forward frame checker for the 34-bit gateway message-word path.
// Each frame is buffered whole. The checker validates the kind sequence
// (head, body*, tail) and confirms that every word carries the ID expected for
// the slot. Clean frames are replayed unmodified over a valid/ready output.
// Faulty frames are dropped, counted and tagged with a cause code.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   in_valid_i     input word valid
//   in_word_i      [33:32] kind (00 idle, 01 head, 10 body, 11 tail),
//                  [31:28] ID, [27:0] payload
//   in_ready_o     block can accept a word (low only while draining)
//   exp_id_i       expected ID for the current slot, sampled on head accept
//   out_valid_o    output word valid
//   out_word_o     forwarded word, zero while out_valid_o is low
//   out_ready_i    downstream accepts the word
//   fault_o        one-cycle pulse per rejected frame or word
//   fault_code_o   last cause: 01 ID error, 10 sequence error, 11 overflow
//   fault_cnt_o    saturating count of rejected events
//   frame_cnt_o    saturating count of forwarded frames
module frame_id_guard #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [33:0]      in_word_i,
    output logic             in_ready_o,
    input  logic [3:0]       exp_id_i,
    output logic             out_valid_o,
    output logic [33:0]      out_word_o,
    input  logic             out_ready_i,
    output logic             fault_o,
    output logic [1:0]       fault_code_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = IDX_W + 1;

    localparam logic [1:0] K_HEAD = 2'b01;
    localparam logic [1:0] K_BODY = 2'b10;
    localparam logic [1:0] K_TAIL = 2'b11;

    localparam logic [1:0] C_ID  = 2'b01;
    localparam logic [1:0] C_SEQ = 2'b10;
    localparam logic [1:0] C_OVF = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   rd_q, rd_d;
    logic [3:0]         id_q, id_d;
    logic               out_valid_q, out_valid_d;
    logic [33:0]        out_word_q, out_word_d;
    logic               fault_q;
    logic [1:0]         fault_code_q;
    logic [CNT_W-1:0]   fault_cnt_q, frame_cnt_q;
    logic [33:0]        mem_q [MAX_LEN];

    logic               acc;
    logic [1:0]         kind;
    logic [3:0]         wid;
    logic               do_head;
    logic               ev;
    logic [1:0]         ev_code;
    logic               frame_inc;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready_o = (state_q != S_DRAIN);
    assign acc        = in_valid_i & in_ready_o;
    assign kind       = in_word_i[33:32];
    assign wid        = in_word_i[31:28];
    assign rd_nxt     = rd_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_d        = rd_q;
        id_d        = id_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        wr_en       = 1'b0;
        wr_idx      = len_q[IDX_W-1:0];
        do_head     = 1'b0;
        ev          = 1'b0;
        ev_code     = 2'b00;
        frame_inc   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (kind == K_HEAD) begin
                        do_head = 1'b1;
                    end else if (kind != 2'b00) begin
                        ev      = 1'b1;
                        ev_code = C_SEQ;
                    end
                end
            end
            S_COLLECT: begin
                if (acc) begin
                    if (kind == K_HEAD) begin
                        // Abandon the open frame; the new head restarts collection.
                        ev      = 1'b1;
                        ev_code = C_SEQ;
                        do_head = 1'b1;
                    end else if (kind != 2'b00) begin
                        if (wid != id_q) begin
                            ev      = 1'b1;
                            ev_code = C_ID;
                            state_d = (kind == K_TAIL) ? S_IDLE : S_DISCARD;
                        end else if (kind == K_BODY && len_q == LEN_W'(MAX_LEN - 1)) begin
                            // Last slot is reserved for the tail.
                            ev      = 1'b1;
                            ev_code = C_OVF;
                            state_d = S_DISCARD;
                        end else begin
                            wr_en = 1'b1;
                            len_d = len_q + 1'b1;
                            if (kind == K_TAIL) begin
                                state_d     = S_DRAIN;
                                out_valid_d = 1'b1;
                                out_word_d  = mem_q[0];
                                rd_d        = '0;
                            end
                        end
                    end
                end
            end
            S_DISCARD: begin
                if (acc) begin
                    if (kind == K_HEAD) begin
                        do_head = 1'b1;
                    end else if (kind == K_TAIL) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready_i) begin
                    if ((LEN_W'(rd_q) + LEN_W'(1)) == len_q) begin
                        out_valid_d = 1'b0;
                        out_word_d  = '0;
                        rd_d        = '0;
                        len_d       = '0;
                        frame_inc   = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rd_d       = rd_nxt;
                        out_word_d = mem_q[rd_nxt];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_head) begin
            if (wid == exp_id_i) begin
                wr_en   = 1'b1;
                wr_idx  = '0;
                id_d    = wid;
                len_d   = LEN_W'(1);
                state_d = S_COLLECT;
            end else begin
                // A sequence fault already raised this cycle takes precedence.
                if (!ev) begin
                    ev      = 1'b1;
                    ev_code = C_ID;
                end
                state_d = S_DISCARD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            rd_q         <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            fault_cnt_q  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            fault_q     <= ev;
            if (ev) begin
                fault_code_q <= ev_code;
                fault_cnt_q  <= sat_inc(fault_cnt_q);
            end
            if (frame_inc) begin
                frame_cnt_q <= sat_inc(frame_cnt_q);
            end
        end
    end

    // Frame storage and latched ID carry data only; no reset needed.
    always_ff @(posedge clk_i) begin
        id_q <= id_d;
        if (wr_en) begin
            mem_q[wr_idx] <= in_word_i;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_word_o   = out_word_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;
    assign fault_cnt_o  = fault_cnt_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: doc/frame_id_guard.md
# frame_id_guard

Store-and-forward checker that sits directly downstream of the TTNI gateway's 34-bit message-word path, including the fault-injection stage. It buffers each frame and validates the frame-kind sequence and the 4-bit ID field [31:28] against the expected ID for the current slot. It forwards only clean frames over a valid/ready interface. Faulty frames are discarded whole, counted, and flagged with a cause code.

## Interface
- MAX_LEN, 16: frame buffer depth in words (power of 2, ≥4); also the maximum legal frame length.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_word  in  34  [33:32] kind (00 idle, 01 head, 10 body, 11 tail), [31:28] ID, [27:0] payload.
- in_ready  out  1  block can accept a word.
- exp_id  in  4  expected ID for the current slot; sampled on head acceptance.
- out_valid  out  1  output word valid.
- out_word  out  34  forwarded word, unmodified.
- out_ready  in  1  downstream accepts the word.
- fault  out  1  one-cycle pulse; a frame or word was rejected.
- fault_code  out  2  cause, held until the next fault: 01 ID error, 10 sequence error, 11 overflow.
- fault_cnt  out  CNT_W  rejected-event count, saturating.
- frame_cnt  out  CNT_W  forwarded-frame count, saturating.

## Operation
- Accept = in_valid & in_ready. Idle-kind (00) words are accepted and ignored in every state.
- **IDLE**
  - Head with ID == exp_id: write to buf[0], latch ID, len=1, go to COLLECT.
  - Head with ID != exp_id: fault code 01, go to DISCARD.
  - Body or tail: orphan word. Fault code 10, drop it, stay in IDLE.
- **COLLECT**
  - Body or tail whose ID differs from the latched ID: fault code 01, go to DISCARD. If the offending word is a tail, go to IDLE instead.
  - Body with len == MAX_LEN-1: fault code 11 (no room left for a tail), go to DISCARD.
  - Otherwise body: store it, len+1.
  - Tail: store it, go to DRAIN.
  - Head: fault code 10. The buffered frame is dropped and the new head is processed exactly as in IDLE, in the same cycle.
- **DISCARD**
  - Drop words until a tail is accepted, then go to IDLE.
  - A head is treated as in IDLE, with no extra fault raised.
- **DRAIN**
  - in_ready=0. Output buf[rd] for rd = 0..len-1, advancing rd on each out_valid & out_ready.
  - On the last handshake: frame_cnt+1, go to IDLE.
- Word order and contents are preserved bit-exactly. Frame length is 2..MAX_LEN words.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - state IDLE, in_ready 1, out_valid 0, out_word 0.
  - fault 0, fault_code 00, fault_cnt 0, frame_cnt 0, len 0, rd 0.
- in_ready = (state != DRAIN), decoded combinationally from registered state.
- fault pulses in the cycle after the offending word is accepted; fault_code and fault_cnt update on that same edge.
- Faults from accepts in back-to-back cycles each pulse and count separately.
- Latency: out_valid rises the cycle after the tail is accepted. A frame of N words needs N cycles minimum to drain.
- out_word is 0 whenever out_valid is 0. While out_valid=1 with out_ready=0, out_word holds stable.
- Once asserted, out_valid stays high until the handshake; it is never withdrawn.
- The first word of the next frame can be accepted the cycle after the last drain handshake.
- rst_n low mid-frame or mid-drain:
  - Buffered data is abandoned and all outputs return to reset values on the next edge.
  - No partial frame is emitted and no fault is reported.

## Test plan
- Clean frame, exp_id=2: head/body/tail with ID 2 and payloads 0x1,0x2,0x3, out_ready=1 -> the 3 identical words appear on consecutive cycles starting 1 cycle after tail accept; frame_cnt=1, fault never pulses.
- Injected ID fault, exp_id=5: head with ID 2 followed by body and tail -> nothing output; one fault pulse with code 01; fault_cnt=1; next clean ID-5 frame passes.
- Mid-frame corruption: head ID 3, body ID 2, tail ID 3 -> frame dropped, code 01, fault_cnt+1, back in IDLE after the tail.
- Overflow with MAX_LEN=4: head plus 3 bodies -> code 11 on the 3rd body; remaining words through the tail are discarded; no output.
- Sequence errors: orphan tail -> code 10; head, body, head(valid), tail -> code 10 once, then the 2-word second frame is forwarded.
- Backpressure and reset: out_ready toggled 1/0 during a 4-word drain -> words held stable with no loss or duplication; rst_n pulled low after 2 words -> out_valid 0 and counters 0 the next cycle.
